// File: rtl/window_feeder_if.sv
// Pixel stream in, convolver load/compute stream and result tags out.
interface window_feeder_if #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DW    = 8
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          conv_data_in;
  logic [1:0]    conv_row;
  logic [1:0]    conv_col;
  logic [DW-1:0] conv_data;
  logic          res_valid;
  logic [XW-1:0] res_x;
  logic [YW-1:0] res_y;
  logic          frame_done;

  modport master (
    output s_valid, s_data,
    input  s_ready, conv_data_in, conv_row, conv_col, conv_data,
           res_valid, res_x, res_y, frame_done
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, conv_data_in, conv_row, conv_col, conv_data,
           res_valid, res_x, res_y, frame_done
  );
endinterface

// File: rtl/window_feeder.sv
// Line-buffered 3x3 window generator; plays each interior window into the
// convolver as 9 indexed loads plus 1 compute cycle.
module window_feeder #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DW    = 8
) (
  input  logic           clk,
  input  logic           reset,
  window_feeder_if.slave bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_CMAX = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_CMAX = YW'(IMG_H - 2);

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_LOAD,
    ST_CALC
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic          res_valid_q, res_valid_d;
  logic          frame_done_q, frame_done_d;

  logic [DW-1:0] lba_q [IMG_W];
  logic [DW-1:0] lba_d [IMG_W];
  logic [DW-1:0] lbb_q [IMG_W];
  logic [DW-1:0] lbb_d [IMG_W];
  logic [DW-1:0] win_q [3][3];
  logic [DW-1:0] win_d [3][3];

  logic s_ready;
  logic accept;

  assign s_ready = (state_q == ST_ACCEPT) & ~reset;
  assign accept  = bus.s_valid & s_ready;

  // Line buffers and window: lbA holds line y-2, lbB line y-1 at column x.
  always_comb begin
    lba_d = lba_q;
    lbb_d = lbb_q;
    win_d = win_q;
    if (accept) begin
      win_d[0][0] = win_q[0][1];
      win_d[0][1] = win_q[0][2];
      win_d[1][0] = win_q[1][1];
      win_d[1][1] = win_q[1][2];
      win_d[2][0] = win_q[2][1];
      win_d[2][1] = win_q[2][2];
      win_d[0][2] = lba_q[x_q];
      win_d[1][2] = lbb_q[x_q];
      win_d[2][2] = bus.s_data;
      lba_d[x_q]  = lbb_q[x_q];
      lbb_d[x_q]  = bus.s_data;
    end
  end

  always_ff @(posedge clk) begin
    lba_q <= lba_d;
    lbb_q <= lbb_d;
    win_q <= win_d;
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    row_d        = row_q;
    col_d        = col_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    res_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        if (accept) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (x_q >= XW'(2) && y_q >= YW'(2)) begin
            state_d = ST_LOAD;
            row_d   = '0;
            col_d   = '0;
            cx_d    = x_q - XW'(1);
            cy_d    = y_q - YW'(1);
          end
        end
      end
      ST_LOAD: begin
        if (col_q == 2'd2) begin
          if (row_q == 2'd2) begin
            state_d = ST_CALC;
          end else begin
            col_d = '0;
            row_d = row_q + 2'd1;
          end
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      ST_CALC: begin
        state_d      = ST_ACCEPT;
        res_valid_d  = 1'b1;
        frame_done_d = (cx_q == X_CMAX) && (cy_q == Y_CMAX);
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ACCEPT;
      x_q          <= '0;
      y_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      res_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      res_valid_q  <= res_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.s_ready      = s_ready;
  assign bus.conv_data_in = (state_q == ST_LOAD);
  assign bus.conv_row     = row_q;
  assign bus.conv_col     = col_q;
  // Window contents are uninitialised after reset; keep the data bus quiet while idle.
  assign bus.conv_data    = (state_q == ST_ACCEPT) ? '0 : win_q[row_q][col_q];
  assign bus.res_valid    = res_valid_q;
  assign bus.res_x        = cx_q;
  assign bus.res_y        = cy_q;
  assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_window_feeder.sv
// Directed bench for window_feeder on a 5x4 frame with pixel(x,y) = 10*y + x.
module tb_window_feeder;
  localparam int W = 5;
  localparam int H = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_feeder_if #(.IMG_W(W), .IMG_H(H), .DW(8)) bus ();

  window_feeder #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] ld_q[$];
  logic [31:0] rs_q[$];
  logic [31:0] exp_ld[$];
  logic [31:0] exp_rs[$];
  int          run_q[$];
  int          run_len  = 0;
  int          stray_fd = 0;
  int          early_res = 0;
  bit          in_early = 1'b0;
  int          n_acc    = 0;
  int          t22      = -1;
  int          t_load   = -1;
  int          t_res    = -1;
  int          gap_tab [8] = '{0, 3, 1, 0, 2, 3, 0, 1};

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (reset) begin
      run_len = 0;
    end else begin
      if (bus.conv_data_in)
        ld_q.push_back(32'(bus.conv_row) * 1024 + 32'(bus.conv_col) * 256 + 32'(bus.conv_data));
      if (bus.res_valid) begin
        rs_q.push_back(32'(bus.res_x) + 32'(bus.res_y) * 16 + 32'(bus.frame_done) * 256);
        if (in_early) early_res++;
      end
      if (bus.frame_done && !bus.res_valid) stray_fd++;
      if (t22 >= 0 && t_load < 0 && bus.conv_data_in) t_load = cyc;
      if (t22 >= 0 && t_res < 0 && bus.res_valid) t_res = cyc;
      if (!bus.s_ready) begin
        run_len++;
      end else if (run_len > 0) begin
        run_q.push_back(run_len);
        run_len = 0;
      end
      if (bus.s_valid && bus.s_ready) begin
        n_acc++;
        if (bus.s_data == 8'd22 && t22 < 0) t22 = cyc;
        if (bus.s_data == 8'd100) in_early = 1'b1;
        if (bus.s_data == 8'd122) in_early = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input int v, input int gap);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'(v);
    forever begin
      @(negedge clk);
      if (bus.s_ready) break;
      n++;
      if (n > 40) begin
        check($sformatf("accept_timeout_px%0d", v), 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (gap > 0) begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'hEE;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int off, input bit gaps, input bit drain);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send_px(10 * y + x + off, gaps ? gap_tab[(y * W + x) % 8] : 0);
    if (drain) begin
      bus.s_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1;
    end
  endtask

  task automatic build_exp(input int off);
    for (int cy = 1; cy <= H - 2; cy++)
      for (int cx = 1; cx <= W - 2; cx++) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_ld.push_back(32'(r * 1024 + c * 256 + 10 * (cy - 1 + r) + (cx - 1 + c) + off));
        exp_rs.push_back(32'(cx + cy * 16 + ((cx == W - 2 && cy == H - 2) ? 256 : 0)));
      end
  endtask

  task automatic clear_all();
    ld_q.delete();
    rs_q.delete();
    exp_ld.delete();
    exp_rs.delete();
    run_q.delete();
    t22    = -1;
    t_load = -1;
    t_res  = -1;
    n_acc  = 0;
  endtask

  task automatic compare_streams(input string tag);
    check({tag, "_n_loads"}, 32'(ld_q.size()), 32'(exp_ld.size()));
    for (int i = 0; i < ld_q.size() && i < exp_ld.size(); i++)
      check($sformatf("%s_load%0d", tag, i), ld_q[i], exp_ld[i]);
    check({tag, "_n_results"}, 32'(rs_q.size()), 32'(exp_rs.size()));
    for (int i = 0; i < rs_q.size() && i < exp_rs.size(); i++)
      check($sformatf("%s_res%0d", tag, i), rs_q[i], exp_rs[i]);
  endtask

  task automatic check_latency(input string tag);
    check({tag, "_first_load_lat"}, 32'(t_load - t22), 32'd1);
    check({tag, "_first_res_lat"}, 32'(t_res - t22), 32'd11);
  endtask

  initial begin
    int n;
    int nfd;
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // Test 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready_low", 32'(bus.s_ready), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    align();
    reset = 1'b0;
    @(negedge clk);
    check("t1_s_ready", 32'(bus.s_ready), 32'd1);
    check("t1_conv_data_in", 32'(bus.conv_data_in), 32'd0);
    check("t1_conv_row", 32'(bus.conv_row), 32'd0);
    check("t1_conv_col", 32'(bus.conv_col), 32'd0);
    check("t1_conv_data", 32'(bus.conv_data), 32'd0);
    check("t1_res_valid", 32'(bus.res_valid), 32'd0);
    check("t1_res_x", 32'(bus.res_x), 32'd0);
    check("t1_res_y", 32'(bus.res_y), 32'd0);
    check("t1_frame_done", 32'(bus.frame_done), 32'd0);

    // Tests 2 and 3: one full-rate frame
    clear_all();
    align();
    send_frame(0, 1'b0, 1'b1);
    build_exp(0);
    compare_streams("t2");
    check_latency("t2");
    nfd = 0;
    foreach (rs_q[i]) if (rs_q[i][8]) nfd++;
    check("t3_frame_done_count", 32'(nfd), 32'd1);

    // Test 4: s_valid held through LOAD plus stream gaps
    clear_all();
    send_frame(0, 1'b1, 1'b1);
    build_exp(0);
    compare_streams("t4");
    check("t4_accepts", 32'(n_acc), 32'd20);
    check("t4_stall_runs", 32'(run_q.size()), 32'd6);
    foreach (run_q[i]) check($sformatf("t4_stall_len%0d", i), 32'(run_q[i]), 32'd10);

    // Test 5: back-to-back frames, second offset by 100
    clear_all();
    early_res = 0;
    send_frame(0, 1'b0, 1'b0);
    send_frame(100, 1'b0, 1'b1);
    build_exp(0);
    build_exp(100);
    compare_streams("t5");
    check("t5_early_results", 32'(early_res), 32'd0);

    // Test 6: reset on the 4th load cycle, then a clean frame
    clear_all();
    for (int p = 0; p < 3 * W; p++)
      if (p / W < 2 || p % W <= 2) send_px(10 * (p / W) + (p % W), 0);
    bus.s_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.conv_data_in && bus.conv_row == 2'd1 && bus.conv_col == 2'd0) && n < 20);
    check("t6_load4_cycle", 32'(n), 32'd4);
    check("t6_load4_data", 32'(bus.conv_data), 32'd10);
    reset = 1'b1;
    align();
    reset = 1'b0;
    @(negedge clk);
    check("t6_conv_data_in", 32'(bus.conv_data_in), 32'd0);
    check("t6_res_valid", 32'(bus.res_valid), 32'd0);
    check("t6_s_ready", 32'(bus.s_ready), 32'd1);
    rs_q.delete();
    repeat (15) @(negedge clk);
    check("t6_no_aborted_result", 32'(rs_q.size()), 32'd0);
    clear_all();
    align();
    send_frame(0, 1'b0, 1'b1);
    build_exp(0);
    compare_streams("t6");
    check_latency("t6");

    check("frame_done_outside_res_valid", 32'(stray_fd), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
